// File: rtl/cpu_execute_unit_if.sv
// Execute-stage bus: decoded instruction fields in,
// registered write-back and branch decision out.
interface cpu_execute_unit_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        OPCODE;
  logic [DATA_W-1:0] DATA1;
  logic [DATA_W-1:0] DATA2;
  logic [DATA_W-1:0] IMMEDIATE;
  logic [DATA_W-1:0] RESULT;
  logic              ZERO;
  logic              WRITEENABLE;
  logic              PCSELECT;
  logic [2:0]        ALUOP;
  logic              ILLEGAL;

  modport master (
    output OPCODE, DATA1, DATA2, IMMEDIATE,
    input  RESULT, ZERO, WRITEENABLE,
    input  PCSELECT, ALUOP, ILLEGAL
  );

  modport slave (
    input  OPCODE, DATA1, DATA2, IMMEDIATE,
    output RESULT, ZERO, WRITEENABLE,
    output PCSELECT, ALUOP, ILLEGAL
  );
endinterface

// File: rtl/cpu_execute_unit.sv
// Execute stage: decode, operand conditioning, ALU and
// branch decision, all captured in one output register.
module cpu_execute_unit #(
  parameter int DATA_W = 8
) (
  input logic CLK,
  input logic RESET,
  cpu_execute_unit_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } aluop_e;

  aluop_e            aluop_d;
  logic              neg;
  logic              immsel;
  logic              we_d;
  logic              jump;
  logic              beq;
  logic              bne;
  logic              ill_d;
  logic [DATA_W-1:0] negv;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] result_d;
  logic              zero_d;
  logic              pcsel_d;

  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              we_q;
  logic              pcsel_q;
  logic [2:0]        aluop_q;
  logic              ill_q;

  // Opcode decode into ALU op and control strobes
  always_comb begin
    aluop_d = ALU_FWD;
    neg     = 1'b0;
    immsel  = 1'b0;
    we_d    = 1'b0;
    jump    = 1'b0;
    beq     = 1'b0;
    bne     = 1'b0;
    ill_d   = 1'b0;
    case (bus.OPCODE)
      8'h00: begin
        immsel = 1'b1;
        we_d   = 1'b1;
      end
      8'h01: we_d = 1'b1;
      8'h02: begin
        aluop_d = ALU_ADD;
        we_d    = 1'b1;
      end
      8'h03: begin
        aluop_d = ALU_ADD;
        neg     = 1'b1;
        we_d    = 1'b1;
      end
      8'h04: begin
        aluop_d = ALU_AND;
        we_d    = 1'b1;
      end
      8'h05: begin
        aluop_d = ALU_OR;
        we_d    = 1'b1;
      end
      8'h06: jump = 1'b1;
      8'h07: begin
        aluop_d = ALU_ADD;
        neg     = 1'b1;
        beq     = 1'b1;
      end
      8'h08: begin
        aluop_d = ALU_ADD;
        neg     = 1'b1;
        bne     = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

  // Two's complement of DATA2 and operand-2 select
  always_comb begin
    negv = ~bus.DATA2 + DATA_W'(1);
    if (immsel)
      op2 = bus.IMMEDIATE;
    else if (neg)
      op2 = negv;
    else
      op2 = bus.DATA2;
  end

  // ALU, zero flag and branch decision
  always_comb begin
    result_d = '0;
    case (aluop_d)
      ALU_FWD: result_d = op2;
      ALU_ADD: result_d = bus.DATA1 + op2;
      ALU_AND: result_d = bus.DATA1 & op2;
      ALU_OR:  result_d = bus.DATA1 | op2;
      default: result_d = '0;
    endcase
    zero_d  = (result_d == '0);
    pcsel_d = jump | (beq & zero_d) |
              (bne & ~zero_d);
  end

  // Output register, cleared asynchronously by RESET
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      we_q     <= 1'b0;
      pcsel_q  <= 1'b0;
      aluop_q  <= 3'b000;
      ill_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      we_q     <= we_d;
      pcsel_q  <= pcsel_d;
      aluop_q  <= aluop_d;
      ill_q    <= ill_d;
    end
  end

  assign bus.RESULT      = result_q;
  assign bus.ZERO        = zero_q;
  assign bus.WRITEENABLE = we_q;
  assign bus.PCSELECT    = pcsel_q;
  assign bus.ALUOP       = aluop_q;
  assign bus.ILLEGAL     = ill_q;

endmodule

// File: tb/tb_cpu_execute_unit.sv
// Directed bench for cpu_execute_unit: vector table
// plus reset sequences.
module tb_cpu_execute_unit;

  logic CLK;
  logic RESET;

  cpu_execute_unit_if #(.DATA_W(8)) ifc ();

  cpu_execute_unit #(.DATA_W(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {RESULT, ZERO, WE, PCSELECT, ALUOP, ILLEGAL}
  logic [14:0] outs;
  assign outs = {ifc.RESULT, ifc.ZERO,
                 ifc.WRITEENABLE, ifc.PCSELECT,
                 ifc.ALUOP, ifc.ILLEGAL};

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [7:0]  imm;
    logic [14:0] exp;
    logic [14:0] mask;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [14:0] ALL  = 15'h7FFF;
  localparam logic [14:0] NORZ = 15'h003F;

  function automatic logic [14:0] pk(
    input logic [7:0] r, input logic z,
    input logic we, input logic pc,
    input logic [2:0] a, input logic il);
    return {r, z, we, pc, a, il};
  endfunction

  function automatic vec_t mk(
    input string n, input logic [7:0] op,
    input logic [7:0] d1, input logic [7:0] d2,
    input logic [7:0] imm, input logic [14:0] e,
    input logic [14:0] m);
    vec_t v;
    v.name = n; v.op = op; v.d1 = d1;
    v.d2 = d2; v.imm = imm; v.exp = e;
    v.mask = m;
    return v;
  endfunction

  task automatic check(input string n,
                       input logic [14:0] e,
                       input logic [14:0] m);
    checks++;
    if ((outs & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h)",
               n, outs, e, m);
    end
  endtask

  task automatic drive(input logic [7:0] op,
                       input logic [7:0] d1,
                       input logic [7:0] d2,
                       input logic [7:0] imm);
    ifc.OPCODE    = op;
    ifc.DATA1     = d1;
    ifc.DATA2     = d2;
    ifc.IMMEDIATE = imm;
  endtask

  initial begin
    vecs.push_back(mk("loadi", 8'h00, 8'h11, 8'h22,
      8'h2A, pk(8'h2A, 0, 1, 0, 3'b000, 0), ALL));
    vecs.push_back(mk("loadi0", 8'h00, 8'h11, 8'h22,
      8'h00, pk(8'h00, 1, 1, 0, 3'b000, 0), ALL));
    vecs.push_back(mk("mov", 8'h01, 8'h11, 8'h7F,
      8'h55, pk(8'h7F, 0, 1, 0, 3'b000, 0), ALL));
    vecs.push_back(mk("add_wrap", 8'h02, 8'hFF, 8'h02,
      8'h00, pk(8'h01, 0, 1, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("add_noimm", 8'h02, 8'h03, 8'h04,
      8'hFF, pk(8'h07, 0, 1, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("sub_neg", 8'h03, 8'h05, 8'h07,
      8'h00, pk(8'hFE, 0, 1, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("sub_80", 8'h03, 8'h00, 8'h80,
      8'h00, pk(8'h80, 0, 1, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("sub_zero", 8'h03, 8'h33, 8'h33,
      8'h00, pk(8'h00, 1, 1, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("sub_d2_0", 8'h03, 8'h42, 8'h00,
      8'h00, pk(8'h42, 0, 1, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("and", 8'h04, 8'hF0, 8'h3C,
      8'h00, pk(8'h30, 0, 1, 0, 3'b010, 0), ALL));
    vecs.push_back(mk("or", 8'h05, 8'hF0, 8'h3C,
      8'h00, pk(8'hFC, 0, 1, 0, 3'b011, 0), ALL));
    vecs.push_back(mk("beq_eq", 8'h07, 8'h09, 8'h09,
      8'h00, pk(8'h00, 1, 0, 1, 3'b001, 0), ALL));
    vecs.push_back(mk("beq_ne", 8'h07, 8'h09, 8'h08,
      8'h00, pk(8'h01, 0, 0, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("bne_ne", 8'h08, 8'h09, 8'h08,
      8'h00, pk(8'h01, 0, 0, 1, 3'b001, 0), ALL));
    vecs.push_back(mk("bne_eq", 8'h08, 8'h09, 8'h09,
      8'h00, pk(8'h00, 1, 0, 0, 3'b001, 0), ALL));
    vecs.push_back(mk("jump", 8'h06, 8'h01, 8'h02,
      8'h03, pk(8'h00, 0, 0, 1, 3'b000, 0), NORZ));
    vecs.push_back(mk("ill_ff", 8'hFF, 8'h01, 8'h5A,
      8'h00, pk(8'h5A, 0, 0, 0, 3'b000, 1), ALL));
    vecs.push_back(mk("ill_09", 8'h09, 8'h07, 8'h00,
      8'h00, pk(8'h00, 1, 0, 0, 3'b000, 1), ALL));

    // Reset held low: outputs stay cleared across edges
    RESET = 1'b0;
    drive(8'h02, 8'h05, 8'h03, 8'h00);
    #2;
    check("rst_pre", '0, ALL);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold", '0, ALL);

    // Release and take one edge
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_first", pk(8'h08, 0, 1, 0, 3'b001, 0),
          ALL);

    // Back-to-back table vectors, one per cycle
    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].op, vecs[i].d1,
            vecs[i].d2, vecs[i].imm);
      @(posedge CLK);
      #1;
      check(vecs[i].name, vecs[i].exp, vecs[i].mask);
    end

    // Illegal opcode, then asynchronous reset mid-cycle
    @(negedge CLK);
    drive(8'hFF, 8'h00, 8'h11, 8'h00);
    @(posedge CLK);
    #1;
    check("ill_pre_rst", pk(8'h11, 0, 0, 0, 3'b000, 1),
          ALL);
    #2;
    RESET = 1'b0;
    #1;
    check("rst_async", '0, ALL);
    @(posedge CLK);
    #1;
    check("rst_async_hold", '0, ALL);

    // Recovery after mid-cycle reset
    @(negedge CLK);
    RESET = 1'b1;
    drive(8'h04, 8'hAA, 8'h0F, 8'h00);
    @(posedge CLK);
    #1;
    check("recover_and", pk(8'h0A, 0, 1, 0, 3'b010, 0),
          ALL);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_execute_unit.md
Name: cpu_execute_unit

Overview:
Execute-stage block for the 8-bit single-cycle CPU. It merges three functions:
- opcode decode (control unit);
- operand conditioning (two's complementer, SUB mux, immediate/register mux);
- the ALU, plus branch-decision logic (beq/bne/j).

Inputs come from the instruction decoder and register file. Registered outputs feed register-file write-back and the PC-select mux.

Parameters:
DATA_W, 8, operand/result width (only 8 is required to be verified).

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous, active-low reset
OPCODE  input  8  instruction bits [31:24]
DATA1  input  8  register-file read port 1 (operand 1)
DATA2  input  8  register-file read port 2 (operand 2)
IMMEDIATE  input  8  instruction bits [7:0]
RESULT  output  8  registered ALU result (write-back data)
ZERO  output  1  registered flag, 1 when ALU result == 0
WRITEENABLE  output  1  registered register-file write enable
PCSELECT  output  1  registered, 1 = take branch/jump target, 0 = PC+4
ALUOP  output  3  registered ALU operation code (debug/visibility)
ILLEGAL  output  1  registered, 1 when OPCODE is not in the ISA

Behaviour:
- Reset:
  - RESET low asynchronously clears every output to 0: RESULT=0x00, ZERO=0, WRITEENABLE=0, PCSELECT=0, ALUOP=000, ILLEGAL=0.
  - Outputs hold 0 while RESET is low.
  - Registers update again on the first rising CLK edge after RESET goes high.
- Latency: all decode/ALU logic is combinational. Outputs capture it on the rising CLK edge, so latency is 1 cycle. Inputs must be stable before the edge.
- Decode (OPCODE -> ALUOP, NEG, IMMSEL, WE, branch type):
  - 0x00 loadi: FWD(000), IMMSEL=1, WE=1
  - 0x01 mov: FWD(000), reg operand, WE=1
  - 0x02 add: ADD(001), reg operand, WE=1
  - 0x03 sub: ADD(001), NEG=1, reg operand, WE=1
  - 0x04 and: AND(010), reg operand, WE=1
  - 0x05 or: OR(011), reg operand, WE=1
  - 0x06 j: WE=0, JUMP=1
  - 0x07 beq: ADD, NEG=1, reg operand, WE=0, BEQ=1
  - 0x08 bne: ADD, NEG=1, reg operand, WE=0, BNE=1
  - any other opcode: FWD, reg operand, WE=0, no branch, ILLEGAL=1
- Complementer: NEGV = (~DATA2)+1, modulo 256. Edge cases: 0x00 -> 0x00, 0x80 -> 0x80.
- Operand 2 (OP2) selection:
  - OP2 = IMMEDIATE when IMMSEL=1.
  - Otherwise OP2 = NEGV when NEG=1, else DATA2.
- ALU operations (operand 1 = DATA1):
  - FWD: result = OP2.
  - ADD: result = (DATA1 + OP2) mod 256, carry discarded, no overflow flag.
  - AND: result = bitwise AND of DATA1 and OP2.
  - OR: result = bitwise OR of DATA1 and OP2.
  - ALUOP codes 1xx and any unused code: result = 0x00.
- ZERO is computed from the combinational ALU result for every opcode, including non-branches.
- Branch decision: PCSELECT = JUMP | (BEQ & zero) | (BNE & ~zero).
- j: ALU result is don't-care but must still be registered; WE=0.
- Back-to-back instructions: each cycle is independent; no state is carried between cycles except the output registers.
- Reset asserted mid-cycle: outputs go to 0 immediately, without waiting for a CLK edge; no partial write-enable may be seen.

Test Plan:
1. Reset: RESET=0 with OPCODE=0x02, DATA1=5, DATA2=3 -> all outputs 0 both before and after CLK edges. Release RESET, clock once -> RESULT=0x08, WRITEENABLE=1, ZERO=0, ALUOP=001.
2. loadi and mov:
   - OPCODE=0x00, IMMEDIATE=0x2A -> RESULT=0x2A, WE=1.
   - OPCODE=0x01, DATA2=0x7F -> RESULT=0x7F.
3. add/sub wrap:
   - add with DATA1=0xFF, DATA2=0x02 -> RESULT=0x01.
   - sub with DATA1=0x05, DATA2=0x07 -> RESULT=0xFE.
   - sub with DATA1=0x00, DATA2=0x80 -> RESULT=0x80.
   - sub with DATA1=DATA2=0x33 -> RESULT=0x00, ZERO=1.
4. Logic: DATA1=0xF0, DATA2=0x3C:
   - and -> RESULT=0x30.
   - or -> RESULT=0xFC.
   - WE=1 and PCSELECT=0 for both.
5. Branches:
   - beq with 9,9 -> PCSELECT=1, WE=0.
   - beq with 9,8 -> PCSELECT=0.
   - bne with 9,8 -> PCSELECT=1.
   - bne with 9,9 -> PCSELECT=0.
   - j (0x06) -> PCSELECT=1, WE=0.
6. Illegal opcode: OPCODE=0xFF -> ILLEGAL=1, WE=0, PCSELECT=0. Then assert RESET low between clock edges -> ILLEGAL drops to 0 immediately.
